ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Parametrised instruction-fetch unit with a prefetch queue. It issues sequential single-beat AXI4 reads from the instruction memory, with up to DEPTH requests in flight or buffered. Returned instructions are queued and handed downstream over a valid/ready interface. A redirect input flushes the queue, discards stale responses and restarts fetch at a new PC. It sits between the core's decode stage and the AXI master port of the rvseed fetch path.

## Interface
- ADDR_W, 32: PC and AXI address width.
- DATA_W, 32: instruction and AXI data width. Must be 32 or 64.
- ID_W, 4: AXI ID width.
- AXI_ID, 0: constant arid value.
- DEPTH, 4: maximum requests in flight plus queued instructions. Power of 2, range 2..16.
- BASE_ADDR, 0: instruction memory base address added to the PC.
- RESET_PC, 0: first fetch PC.
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  fetch permitted
- redirect_valid  in  1  restart fetch. Single-cycle pulse, no handshake.
- redirect_pc  in  ADDR_W  new PC. Word aligned.
- axi_mst_arvalid/arready  out/in  1  AR handshake
- axi_mst_arid  out  ID_W; axi_mst_araddr  out  ADDR_W
- axi_mst_arlen  out  8; axi_mst_arsize  out  3; axi_mst_arburst  out  2; axi_mst_arlock  out  1
- axi_mst_arcache  out  4; axi_mst_arprot  out  3; axi_mst_arqos  out  4; axi_mst_arregion  out  4
- axi_mst_rvalid/rready  in/out  1  R handshake
- axi_mst_rid  in  ID_W; axi_mst_rdata  in  DATA_W; axi_mst_rresp  in  2; axi_mst_rlast  in  1
- inst_valid/inst_ready  out/in  1  instruction handshake
- inst_pc  out  ADDR_W; inst  out  DATA_W; inst_err  out  1  bus error on this fetch

## Operation
- Constant AR fields:
  - arlen 0, arsize clog2(DATA_W/8), arburst INCR (2'b01).
  - arid AXI_ID.
  - arlock, arcache, arprot, arqos and arregion all 0.
- Registers:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next non-dropped response.
  - inflight_cnt: AR accepted, R not yet received.
  - drop_cnt: responses still to discard.
  - FIFO of DEPTH entries holding {pc, data, err}, with fifo_cnt.
- Occupancy is inflight_cnt + fifo_cnt + arvalid.
- A new request is raised, registered, on the next cycle when all of these hold:
  - enable = 1 and redirect_valid = 0;
  - arvalid = 0, or arvalid & arready this cycle;
  - occupancy < DEPTH.
- On raising a request: araddr = BASE_ADDR + fetch_pc, then fetch_pc += DATA_W/8.
- arvalid and araddr stay stable until arready, regardless of enable or redirect.
- inflight_cnt increments on AR handshake and decrements on R handshake. Both in the same cycle leaves it unchanged.
- rready is 1 whenever not in reset. Credit accounting guarantees FIFO space.
- R beat with drop_cnt > 0: the beat is discarded and drop_cnt decrements.
- R beat with drop_cnt = 0: push {resp_pc, rdata, rresp[1]}, then resp_pc += DATA_W/8.
- rid and rlast are not checked.
- Pop on inst_valid & inst_ready. inst_valid = (fifo_cnt != 0). inst, inst_pc and inst_err show the FIFO head.
- Redirect takes priority over push and pop in the same cycle:
  - fifo_cnt becomes 0;
  - fetch_pc and resp_pc both load redirect_pc;
  - drop_cnt becomes inflight_cnt + arvalid − (R handshake this cycle ? 1 : 0). An R beat in the redirect cycle is discarded.
- A pending arvalid at redirect is already counted in drop_cnt. Its later acceptance adds nothing further to drop_cnt.
- Error response (rresp SLVERR/DECERR): the entry carries inst_err = 1. Fetch continues.
- enable low: no new requests. Outstanding reads complete and fill the FIFO.
- Reset mid-operation clears all state immediately. In-flight bus responses after reset release are not tracked; the system resets the slave together with this block.

## Timing
- Reset values:
  - arvalid 0, araddr BASE_ADDR + RESET_PC, rready 0.
  - inst_valid 0, inst 0, inst_pc 0, inst_err 0.
  - fetch_pc and resp_pc RESET_PC; all counters 0.
- First arvalid: 1 cycle after rst deasserts with enable = 1.
- R beat accepted in cycle t: inst_valid = 1 in t+1. No combinational path from R to the inst outputs.
- Sustained throughput: 1 instruction per cycle when the slave returns 1 beat per cycle and inst_ready = 1.
- Throughput is limited by DEPTH ÷ round-trip latency.
- A pop in cycle t frees a credit from t+1. There is no same-cycle credit reuse.
- Redirect in cycle t:
  - inst_valid = 0 in t+1;
  - first request to redirect_pc raised in t+1 if arvalid is free, otherwise 1 cycle after the pending AR handshake.
- Full FIFO (fifo_cnt = DEPTH): no requests issue while inst_ready = 0. inflight_cnt is 0 in this state.
- PC arithmetic wraps modulo 2^ADDR_W.

## Test plan
- Streaming:
  - Stimulus: RESET_PC = 0, BASE_ADDR = 0x8000_0000, 1-cycle-latency slave, inst_ready = 1.
  - Required: araddr 0x8000_0000, 0x8000_0004, …; inst_pc 0, 4, 8, … each cycle; inst matches memory.
- Backpressure:
  - Stimulus: DEPTH = 4, inst_ready = 0 for 20 cycles.
  - Required: exactly 4 AR handshakes, fifo_cnt = 4, arvalid low.
  - Then inst_ready = 1: 4 pops in order, after which fetch resumes.
- Redirect with 3 in flight:
  - Stimulus: slave latency 5, redirect_pc = 0x100 while inflight_cnt = 3.
  - Required: 3 responses discarded; next inst_pc = 0x100 with data from BASE_ADDR + 0x100.
- Redirect during stalled AR:
  - Stimulus: arready = 0 for 4 cycles around the redirect.
  - Required: araddr unchanged until handshake; that response dropped; next araddr = BASE_ADDR + redirect_pc.
- Error and enable:
  - Stimulus: SLVERR on PC 0x8; then enable = 0 with 2 in flight.
  - Required: inst_err = 1 only for inst_pc 0x8; both in-flight responses delivered; no further arvalid.
- Async reset mid-burst:
  - Stimulus: rst asserted between clock edges.
  - Required: arvalid and inst_valid drop to 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: issues single-beat AXI4 reads into a credit-limited
// queue and hands instructions downstream; a redirect flushes the queue and drops stale beats.
module ifu_prefetch #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                ID_W      = 4,
    parameter logic [ID_W-1:0]   AXI_ID    = '0,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              axi_mst_arvalid,
    input  logic              axi_mst_arready,
    output logic [ID_W-1:0]   axi_mst_arid,
    output logic [ADDR_W-1:0] axi_mst_araddr,
    output logic [7:0]        axi_mst_arlen,
    output logic [2:0]        axi_mst_arsize,
    output logic [1:0]        axi_mst_arburst,
    output logic              axi_mst_arlock,
    output logic [3:0]        axi_mst_arcache,
    output logic [2:0]        axi_mst_arprot,
    output logic [3:0]        axi_mst_arqos,
    output logic [3:0]        axi_mst_arregion,
    input  logic              axi_mst_rvalid,
    output logic              axi_mst_rready,
    input  logic [ID_W-1:0]   axi_mst_rid,
    input  logic [DATA_W-1:0] axi_mst_rdata,
    input  logic [1:0]        axi_mst_rresp,
    input  logic              axi_mst_rlast,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [DATA_W-1:0] inst,
    output logic              inst_err
);

    localparam int                STEP_B = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(STEP_B);
    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam int                OCC_W  = CNT_W + 1;

    assign axi_mst_arid     = AXI_ID;
    assign axi_mst_arlen    = 8'd0;
    assign axi_mst_arsize   = 3'($clog2(STEP_B));
    assign axi_mst_arburst  = 2'b01;
    assign axi_mst_arlock   = 1'b0;
    assign axi_mst_arcache  = 4'd0;
    assign axi_mst_arprot   = 3'd0;
    assign axi_mst_arqos    = 4'd0;
    assign axi_mst_arregion = 4'd0;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  inflight_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  err_mem;

    logic             ar_hs;
    logic             r_hs;
    logic             push;
    logic             pop;
    logic             issue;
    logic [OCC_W-1:0] occupancy;

    // rid and rlast carry no information for single-beat, single-ID reads
    logic unused_r;
    assign unused_r = ^{axi_mst_rid, axi_mst_rlast, axi_mst_rresp[0]};

    assign ar_hs     = axi_mst_arvalid & axi_mst_arready;
    assign r_hs      = axi_mst_rvalid & axi_mst_rready;
    assign push      = r_hs & (drop_cnt == '0) & ~redirect_valid;
    assign pop       = inst_valid & inst_ready;
    assign occupancy = OCC_W'(inflight_cnt) + OCC_W'(fifo_cnt) + OCC_W'(axi_mst_arvalid);
    // Credits use this cycle's registered counts, so a pop only frees a slot next cycle
    assign issue     = enable & ~redirect_valid & (~axi_mst_arvalid | ar_hs)
                     & (occupancy < OCC_W'(DEPTH));

    assign inst_valid = (fifo_cnt != '0);
    assign inst_pc    = pc_mem[rd_ptr];
    assign inst       = data_mem[rd_ptr];
    assign inst_err   = err_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axi_mst_arvalid <= 1'b0;
            axi_mst_araddr  <= BASE_ADDR + RESET_PC;
            axi_mst_rready  <= 1'b0;
            fetch_pc        <= RESET_PC;
            inflight_cnt    <= '0;
        end else begin
            axi_mst_rready <= 1'b1;
            if (issue) begin
                axi_mst_arvalid <= 1'b1;
                axi_mst_araddr  <= BASE_ADDR + fetch_pc;
            end else if (ar_hs) begin
                axi_mst_arvalid <= 1'b0;
            end

            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + STEP;
            end

            if (ar_hs && !r_hs) begin
                inflight_cnt <= inflight_cnt + CNT_W'(1);
            end else if (!ar_hs && r_hs) begin
                inflight_cnt <= inflight_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_pc  <= RESET_PC;
            drop_cnt <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err_mem  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Everything already requested, including a still-pending AR, becomes stale
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            resp_pc  <= redirect_pc;
            drop_cnt <= inflight_cnt + CNT_W'(axi_mst_arvalid) - CNT_W'(r_hs);
        end else begin
            if (r_hs && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push) begin
                pc_mem[wr_ptr]   <= resp_pc;
                data_mem[wr_ptr] <= axi_mst_rdata;
                err_mem[wr_ptr]  <= axi_mst_rresp[1];
                wr_ptr           <= wr_ptr + PTR_W'(1);
                resp_pc          <= resp_pc + STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: in-order AXI slave model plus an instruction-stream reference
// (expected PC sequence, redirect epochs) checked every cycle, with directed scenarios.
module tb_ifu_prefetch;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] ERR_PC = 32'h8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [3:0]  arregion;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b1;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_err;

    ifu_prefetch #(
        .ADDR_W(32), .DATA_W(32), .ID_W(4), .AXI_ID(4'd0), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
        .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
        .axi_mst_arburst(arburst), .axi_mst_arlock(arlock), .axi_mst_arcache(arcache),
        .axi_mst_arprot(arprot), .axi_mst_arqos(arqos), .axi_mst_arregion(arregion),
        .axi_mst_rvalid(rvalid), .axi_mst_rready(rready), .axi_mst_rid(rid),
        .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
        .inst(inst), .inst_err(inst_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } ins_t;

    req_t        sq[$];
    ins_t        eq[$];
    logic [31:0] exp_ar = BASE + RST_PC;
    bit          redir_pend = 0;
    logic [31:0] pend_pc = '0;
    bit          r_hold = 0;

    int ar_mode = 0;   // 0 always ready, 1 random, 2 stalled
    int ir_mode = 1;   // 0 never, 1 always, 2 random
    int lat = 1;       // 0 = random latency per request
    int cyc = 0;
    int ar_cnt = 0;
    int pop_cnt = 0;
    int err_pop_cnt = 0;
    bit want_first = 0;
    bit got_first = 0;
    logic [31:0] first_pc = '0;
    logic [31:0] first_inst = '0;

    int total = 0;
    int bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave and reference model: inputs change at negedge, handshakes land on the next posedge
    always @(negedge clk) begin
        bit   ar_hs;
        bit   r_hs;
        bit   pop;
        bit   redir;
        req_t e;
        if (rst) begin
            sq.delete();
            eq.delete();
            exp_ar     = BASE + RST_PC;
            redir_pend = 0;
            r_hold     = 0;
            rvalid     = 1'b0;
            arready    = 1'b0;
        end else begin
            cyc++;
            case (ar_mode)
                0:       arready = 1'b1;
                1:       arready = 1'($urandom_range(0, 1));
                default: arready = 1'b0;
            endcase
            if (!r_hold) begin
                rvalid = 1'b0;
                if (sq.size() != 0) begin
                    if (sq[0].rdy <= cyc && (ar_mode != 1 || $urandom_range(0, 3) != 0))
                        rvalid = 1'b1;
                end
            end
            if (rvalid) begin
                rdata = mem_word(sq[0].addr);
                rresp = ((sq[0].addr - BASE) == ERR_PC) ? 2'b10 : 2'b00;
            end else begin
                rdata = $urandom;
                rresp = 2'($urandom_range(0, 3));
            end
            rid = 4'($urandom_range(0, 15));
            case (ir_mode)
                0:       inst_ready = 1'b0;
                1:       inst_ready = 1'b1;
                default: inst_ready = 1'($urandom_range(0, 1));
            endcase

            ar_hs  = arvalid && arready;
            r_hs   = rvalid && rready;
            pop    = inst_valid && inst_ready;
            redir  = redirect_valid;
            r_hold = rvalid && !rready;

            chk("inst_valid", inst_valid, eq.size() != 0);
            if (eq.size() != 0) begin
                chk("inst_pc", inst_pc, eq[0].pc);
                chk("inst", inst, eq[0].data);
                chk("inst_err", inst_err, eq[0].err);
            end
            if (arvalid) chk("araddr", araddr, exp_ar);

            if (pop) begin
                pop_cnt++;
                if (inst_err) err_pop_cnt++;
                if (want_first && !got_first && !redir) begin
                    first_pc   = inst_pc;
                    first_inst = inst;
                    got_first  = 1;
                end
                if (eq.size() != 0) void'(eq.pop_front());
            end
            if (r_hs && sq.size() != 0) begin
                e = sq.pop_front();
                if (!e.stale && !redir)
                    eq.push_back('{e.addr - BASE, mem_word(e.addr), (e.addr - BASE) == ERR_PC});
            end
            if (ar_hs) begin
                ar_cnt++;
                sq.push_back('{exp_ar, cyc + ((lat != 0) ? lat : $urandom_range(1, 6)), redir_pend});
                if (redir_pend) begin
                    exp_ar     = BASE + pend_pc;
                    redir_pend = 0;
                end else begin
                    exp_ar = exp_ar + 32'd4;
                end
            end
            if (redir) begin
                foreach (sq[i]) sq[i].stale = 1;
                eq.delete();
                if (arvalid && !ar_hs) begin
                    redir_pend = 1;
                    pend_pc    = redirect_pc;
                end else begin
                    exp_ar     = BASE + redirect_pc;
                    redir_pend = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_quiet(input string tag);
        int k = 0;
        while (!(sq.size() == 0 && eq.size() == 0 && arvalid === 1'b0) && k < 400) begin
            step(1);
            k++;
        end
        chk(tag, k < 400, 1);
    endtask

    task automatic wait_inflight(input int n, input string tag);
        int k = 0;
        while (sq.size() < n && k < 100) begin
            step(1);
            k++;
        end
        chk(tag, sq.size() >= n, 1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        want_first     = 1;
        got_first      = 0;
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_first(input string tag);
        int k = 0;
        while (!got_first && k < 200) begin
            step(1);
            k++;
        end
        chk(tag, got_first, 1);
        want_first = 0;
    endtask

    initial begin
        int p0;
        int a0;
        enable = 1'b1;
        #1 rst = 1'b1;
        step(1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, BASE + RST_PC);
        chk("rst_rready", rready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_err", inst_err, 0);
        chk("ar_const", {arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, arregion},
            {8'd0, 3'd2, 2'b01, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
        step(2);
        @(posedge clk);
        #3 rst = 1'b0;
        step(1);
        chk("first_arvalid", arvalid, 1);
        chk("first_araddr", araddr, BASE + RST_PC);

        // streaming at one instruction per cycle
        step(10);
        chk("stream_rready", rready, 1);
        p0 = pop_cnt;
        step(30);
        chk("stream_rate", pop_cnt - p0, 30);
        chk("stream_err_count", err_pop_cnt, 1);

        // backpressure: four credits then stall
        enable = 1'b0;
        wait_quiet("drain_bp");
        ir_mode = 0;
        a0 = ar_cnt;
        enable = 1'b1;
        step(20);
        chk("bp_ar_count", ar_cnt - a0, 4);
        chk("bp_arvalid", arvalid, 0);
        chk("bp_inst_valid", inst_valid, 1);
        ir_mode = 1;
        p0 = pop_cnt;
        step(4);
        chk("bp_pops", pop_cnt - p0, 4);
        a0 = ar_cnt;
        step(6);
        chk("bp_resume", ar_cnt > a0, 1);

        // redirect with three reads in flight
        enable = 1'b0;
        wait_quiet("drain_rd3");
        lat = 5;
        enable = 1'b1;
        wait_inflight(3, "rd3_inflight");
        redirect_to(32'h100);
        chk("rd3_flush", inst_valid, 0);
        wait_first("rd3_first");
        chk("rd3_pc", first_pc, 32'h100);
        chk("rd3_inst", first_inst, mem_word(BASE + 32'h100));

        // redirect while the AR channel is stalled
        lat = 2;
        ar_mode = 2;
        step(4);
        chk("stall_arvalid", arvalid, 1);
        redirect_to(32'h200);
        step(2);
        ar_mode = 0;
        wait_first("stall_first");
        chk("stall_pc", first_pc, 32'h200);
        chk("stall_inst", first_inst, mem_word(BASE + 32'h200));

        // error response and enable drop with reads outstanding
        enable = 1'b0;
        wait_quiet("drain_en");
        lat = 4;
        redirect_to(32'h0);
        p0 = err_pop_cnt;
        enable = 1'b1;
        wait_inflight(2, "en_inflight");
        enable = 1'b0;
        a0 = pop_cnt;
        wait_quiet("en_drain");
        chk("en_delivered", pop_cnt - a0 >= 2, 1);
        chk("en_err_seen", err_pop_cnt - p0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("en_idle_arvalid", arvalid, 0);
        end

        // randomized traffic with random redirects and enable toggles
        ar_mode = 1;
        ir_mode = 2;
        lat = 0;
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = 32'($urandom_range(0, 255)) * 32'd4;
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            step(1);
        end
        redirect_valid = 1'b0;

        // asynchronous reset in the middle of a stream
        ar_mode = 0;
        ir_mode = 1;
        lat = 1;
        enable = 1'b1;
        step(12);
        @(posedge clk);
        #3;
        chk("pre_rst_arvalid", arvalid, 1);
        chk("pre_rst_inst_valid", inst_valid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_arvalid", arvalid, 0);
        chk("async_rst_inst_valid", inst_valid, 0);
        step(2);
        @(posedge clk);
        #3 rst = 1'b0;
        step(1);
        chk("restart_arvalid", arvalid, 1);
        chk("restart_araddr", araddr, BASE + RST_PC);
        step(30);
        enable = 1'b0;
        wait_quiet("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
